serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder controller that sequences a single full-adder slice, built from two half-adder stages, over WIDTH cycles, LSB first. It sits between a requesting master and the shared one-bit half-adder datapath. Operands are captured on a start handshake, and the block walks them through the slice while tracking carry. It presents a stable registered result with a one-cycle done pulse.

---
 rtl/serial_adder_ctrl_if.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a master and serial_adder_ctrl.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, sub, output busy, done, sum, carry_out);
`else
  modport master (output start, a, b, input busy, done, sum, carry_out);
  modport slave  (input start, a, b, output busy, done, sum, carry_out);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half-adder stages) stepped LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a-b via inverted b and carry-in of 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, psum_reg, sum_reg;
  logic [WIDTH-1:0] psum_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg, carry_out_reg, carry_next;
  logic             accept, last_bit, cin, inv_b;
  logic             b_bit, s1, c1, s, c2;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_reg;
  assign cin   = bus.sub;
  assign inv_b = sub_reg;
`else
  assign cin   = 1'b0;
  assign inv_b = 1'b0;
`endif

  // Starts are only honoured outside RUN; DONE may chain straight into a new RUN.
  assign accept   = bus.start && (state_reg != RUN);
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  // Two half-adder stages forming the full-adder slice.
  assign b_bit      = b_sh_reg[0] ^ inv_b;
  assign s1         = a_sh_reg[0] ^ b_bit;
  assign c1         = a_sh_reg[0] & b_bit;
  assign s          = s1 ^ carry_reg;
  assign c2         = s1 & carry_reg;
  assign carry_next = c1 | c2;
  assign psum_next  = {s, psum_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = accept ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      psum_reg      <= '0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_reg       <= 1'b0;
`endif
    end else if (accept) begin
      a_sh_reg  <= bus.a;
      b_sh_reg  <= bus.b;
      psum_reg  <= '0;
      cnt_reg   <= '0;
      carry_reg <= cin;
`ifdef SERIAL_ADDER_SUB_EN
      sub_reg   <= bus.sub;
`endif
    end else if (state_reg == RUN) begin
      a_sh_reg  <= a_sh_reg >> 1;
      b_sh_reg  <= b_sh_reg >> 1;
      psum_reg  <= psum_next;
      cnt_reg   <= cnt_reg + 1'b1;
      carry_reg <= carry_next;
      if (last_bit) begin
        sum_reg       <= psum_next;
        carry_out_reg <= carry_next;
      end
    end
  end

  assign bus.sum       = sum_reg;
  assign bus.carry_out = carry_out_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences, random ops.
// Honours SERIAL_ADDER_SUB_EN when defined.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_co;
  } vec_t;

  vec_t vecs[$];

  // Reference: {carry_out,sum} is a+b+cin in W+1 bits, with b inverted and cin=1 for subtract.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rs);
    logic [W:0] r;
    if (rs) r = {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
    else    r = {1'b0, ra} + {1'b0, rb};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic ds);
    bus.start = st;
    bus.a     = da;
    bus.b     = db;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = ds;
`else
    if (ds) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Called #1 after a clock edge with the DUT idle; runs one full operation with timing checks.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                       input logic [W-1:0] es, input logic eco, input bit verbose);
    drive(1'b1, ta, tb_b, ts);
    @(posedge clk); #1;
    drive(1'b0, W'($urandom), W'($urandom), 1'b0);
    chk("busy_after_start", {30'd0, bus.busy, bus.done}, 32'b10);
    repeat (W - 1) @(posedge clk);
    #1;
    chk("busy_before_done", {30'd0, bus.busy, bus.done}, 32'b10);
    @(posedge clk); #1;
    chk("done_pulse", {30'd0, bus.busy, bus.done}, 32'b01);
    chk("result", {23'd0, bus.carry_out, bus.sum}, {23'd0, eco, es});
    if (verbose)
      $display("op a=%02h b=%02h sub=%0d -> sum=%02h co=%0d (exp %02h %0d)",
               ta, tb_b, ts, bus.sum, bus.carry_out, es, eco);
    @(posedge clk); #1;
    chk("done_drop_hold", {22'd0, bus.busy, bus.done, bus.sum}, {22'd0, 2'b00, es});
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rs;
    int guard;

    vecs.push_back('{a: 8'h0F, b: 8'h01, sub: 1'b0, exp_sum: 8'h10, exp_co: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, sub: 1'b0, exp_sum: 8'h00, exp_co: 1'b1});
    vecs.push_back('{a: 8'hAA, b: 8'h55, sub: 1'b0, exp_sum: 8'hFF, exp_co: 1'b0});
    vecs.push_back('{a: 8'h00, b: 8'h00, sub: 1'b0, exp_sum: 8'h00, exp_co: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, sub: 1'b0, exp_sum: 8'hFE, exp_co: 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{a: 8'h05, b: 8'h07, sub: 1'b1, exp_sum: 8'hFE, exp_co: 1'b0});
    vecs.push_back('{a: 8'h07, b: 8'h05, sub: 1'b1, exp_sum: 8'h02, exp_co: 1'b1});
    vecs.push_back('{a: 8'h33, b: 8'h33, sub: 1'b1, exp_sum: 8'h00, exp_co: 1'b1});
`endif

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {21'd0, bus.busy, bus.done, bus.carry_out, bus.sum}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_sum, vecs[i].exp_co, 1'b1);

    // Start held high: results every W+1 cycles; operands changed mid-RUN only affect the next op.
    drive(1'b1, 8'h80, 8'h80, 1'b0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    bus.a = 8'h01;
    bus.b = 8'h01;
    repeat (W - 3) @(posedge clk);
    #1;
    chk("b2b_done1", {31'd0, bus.done}, 32'd1);
    chk("b2b_result1", {23'd0, bus.carry_out, bus.sum}, {23'd0, 1'b1, 8'h00});
    $display("b2b op1 a=80 b=80 -> sum=%02h co=%0d", bus.sum, bus.carry_out);
    repeat (W) @(posedge clk);
    #1;
    chk("b2b_no_early_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_done2", {31'd0, bus.done}, 32'd1);
    chk("b2b_result2", {23'd0, bus.carry_out, bus.sum}, {23'd0, 1'b0, 8'h02});
    $display("b2b op2 a=01 b=01 -> sum=%02h co=%0d", bus.sum, bus.carry_out);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // Reset mid-operation: outputs clear at once and no done follows.
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    drive(1'b1, 8'hF0, 8'h0F, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {21'd0, bus.busy, bus.done, bus.carry_out, bus.sum}, 32'd0);
    #1;
    rst_n = 1'b1;
    guard = 0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) guard++;
    end
    chk("no_done_after_reset", guard, 0);
    $display("reset mid-op: activity cycles after reset=%0d", guard);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Randomized operations checked against the arithmetic model.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      r = ref_model(ra, rb, rs);
      do_op(ra, rb, rs, r[W-1:0], r[W], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
